hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Parametrised data-hazard, forwarding and stall controller for an in-order hart with NSTG back-end stages.
//  Compares ID-stage source registers against the destinations of back-end stages 0..NSTG-1 (0 = youngest/EX).
//  Selects forwarding sources and drives front-end stall and back-end bubble tracking.
//  Sits between the decode stage and the back-end operand muxes; the global bus/AMO stall is an input.
// PARAMETERS
//  NSTG  3  number of back-end stages tracked (EX..WB); legal range 2..8
//  NREG  32 architectural register count; RW = $clog2(NREG) index bits; register 0 is hardwired zero
//  SELW  derived = (NSTG>2) ? $clog2(NSTG) : 1; width of the forward-select fields
// PORTS
//  clk        in  1         clock, rising edge
//  rst        in  1         asynchronous, active-high reset
//  bus_stall  in  1         global freeze (bus busy, AMO pending); all state holds while high
//  id_rs1     in  RW        ID source register A
//  id_rs1_use in  1         operand A is read from the register file; 0 for PC- or immediate-based operands
//  id_rs2     in  RW        ID source register B
//  id_rs2_use in  1         operand B is read from the register file
//  id_no_fw   in  1         ID consumes its operands before EX (branch, jalr, store); forwarding is not allowed
//  st_rd      in  NSTG*RW   destination register per stage; stage i occupies bits [i*RW +: RW]
//  st_wr      in  NSTG      stage i writes its destination register
//  st_rdy     in  NSTG      stage i result is available for forwarding; 0 for a load before data return
//  stall_fe   out 1         hold IF/PD/ID
//  be_bubble  out NSTG      stage i holds a bubble; the back end must suppress its side effects
//  fw_a_en    out 1         registered: operand A in EX takes the forwarded value
//  fw_a_sel   out SELW      registered: source stage index for operand A
//  fw_b_en    out 1         registered: operand B in EX takes the forwarded value
//  fw_b_sel   out SELW      registered: source stage index for operand B
// BEHAVIOUR
//  Reset (async): stall_cnt = 0, be_bubble = all ones (pipeline empty), fw_*_en = 0, fw_*_sel = 0.
//  Match on operand x at stage i: x_use && rs_x != 0 && st_wr[i] && !be_bubble[i] && st_rd[i] == rs_x.
//    The lowest matching i is the youngest match; only the youngest match per operand is considered.
//  Per operand, with youngest match i:
//    - Forwardable when st_rdy[i] && !id_no_fw (and forwarding is compiled in): no stall.
//    - Matched but not forwardable: hazard. Required wait W = NSTG - i cycles (drain through writeback).
//      Exception: a stage that is not ready (st_rdy = 0) with id_no_fw = 0 gives W = 1, then re-evaluate.
//    - Both operands hazardous: W = max of the two values.
//  Hazard evaluation runs only when stall_cnt == 0 and bus_stall == 0.
//  stall_fe = bus_stall || stall_cnt != 0 || hazard (hazard is combinational in the detecting cycle).
//  Each clock with bus_stall = 0:
//    - be_bubble <= {be_bubble[NSTG-2:0], stall_fe}; a bubble enters stage 0 for every stalled cycle.
//    - On hazard: stall_cnt <= W - 1. Otherwise, if stall_cnt != 0: stall_cnt <= stall_cnt - 1.
//  With bus_stall = 1: stall_cnt, be_bubble and the fw_* outputs all hold.
//  fw_* outputs are updated only on a cycle with !bus_stall && !stall_fe, i.e. when ID advances into EX.
//    They carry the youngest forwardable match. On any other non-frozen cycle, fw_*_en <= 0.
//  stall_cnt width is $clog2(NSTG+1). A W of 0 is impossible. The counter never wraps.
//  Dependencies on register 0 and on bubbled stages are never hazards.
//  If reset asserts mid-stall, all state clears immediately. The first cycle after reset evaluates against an empty pipe.
// CONFIGURATION
//  HAZ_FWD_EN defined: forwarding enabled as described above.
//  HAZ_FWD_EN undefined: every match is a hazard with W = NSTG - i. fw_a_en and fw_b_en are tied to 0.
//    The st_rdy input is ignored.
// TESTING (NSTG=3, HAZ_FWD_EN defined unless stated)
//  1. After reset, ID rs1=5 use=1, no stage writes x5 -> stall_fe=0, next cycle fw_a_en=0, be_bubble=3'b110.
//  2. Stage0 rd=5 wr=1 rdy=1, ID rs1=5 -> stall_fe=0, next cycle fw_a_en=1, fw_a_sel=0.
//     Stage2 rd=7 rdy=1, ID rs2=7 use=1 -> fw_b_sel=2.
//  3. Stage0 load rd=5 rdy=0, ID rs1=5 -> 1-cycle stall, be_bubble[0]=1 next cycle.
//     Match now at stage1 rdy=1 -> fw_a_sel=1.
//  4. Stage0 rd=5, ID branch rs1=5 id_no_fw=1 -> stall_fe high 3 cycles, bubbles at stages 0..2.
//     Then ID advances with fw_a_en=0.
//  5. Hazard with W=3, bus_stall held 4 cycles mid-stall -> stall_cnt and be_bubble frozen.
//     Total stall_fe cycles = 3 + 4.
//  6. HAZ_FWD_EN undefined, stage1 rd=5 rdy=1, ID rs1=5 -> stall_fe 2 cycles.
//     Also: rs1=0 with stage0 rd=0 wr=1 -> no stall. Reset mid-stall -> stall_fe=0 next cycle.

Source files
------------

// File: rtl/hazard_unit_if.sv
// Signal bundle between the decode/back-end pipeline and hazard_unit.
// master = pipeline side (drives ID/stage info), slave = hazard_unit.
interface hazard_unit_if #(
  parameter int NSTG = 3,
  parameter int NREG = 32
);
  localparam int RW   = $clog2(NREG);
  localparam int SELW = (NSTG > 2) ? $clog2(NSTG) : 1;

  logic                 bus_stall;
  logic [RW-1:0]        id_rs1;
  logic                 id_rs1_use;
  logic [RW-1:0]        id_rs2;
  logic                 id_rs2_use;
  logic                 id_no_fw;
  logic [NSTG*RW-1:0]   st_rd;
  logic [NSTG-1:0]      st_wr;
  logic [NSTG-1:0]      st_rdy;
  logic                 stall_fe;
  logic [NSTG-1:0]      be_bubble;
  logic                 fw_a_en;
  logic [SELW-1:0]      fw_a_sel;
  logic                 fw_b_en;
  logic [SELW-1:0]      fw_b_sel;

  modport master (
    output bus_stall, id_rs1, id_rs1_use, id_rs2, id_rs2_use, id_no_fw,
           st_rd, st_wr, st_rdy,
    input  stall_fe, be_bubble, fw_a_en, fw_a_sel, fw_b_en, fw_b_sel
  );

  modport slave (
    input  bus_stall, id_rs1, id_rs1_use, id_rs2, id_rs2_use, id_no_fw,
           st_rd, st_wr, st_rdy,
    output stall_fe, be_bubble, fw_a_en, fw_a_sel, fw_b_en, fw_b_sel
  );
endinterface

// File: rtl/hazard_unit.sv
// Data-hazard, forwarding and stall controller for an in-order hart with NSTG back-end stages.
// Define HAZ_FWD_EN to compile in operand forwarding; without it every dependency stalls to writeback.
module hazard_unit #(
  parameter int NSTG = 3,
  parameter int NREG = 32
) (
  input logic          clk,
  input logic          rst,
  hazard_unit_if.slave haz
);
  localparam int RW   = $clog2(NREG);
  localparam int SELW = (NSTG > 2) ? $clog2(NSTG) : 1;
  localparam int CW   = $clog2(NSTG + 1);

  typedef logic [SELW-1:0] sel_t;
  typedef logic [CW-1:0]   cnt_t;
  typedef struct packed {
    logic hit;
    sel_t idx;
  } match_t;

  cnt_t            stall_cnt_q, stall_cnt_d;
  logic [NSTG-1:0] bubble_q, bubble_d;
  logic            fw_a_en_q, fw_a_en_d, fw_b_en_q, fw_b_en_d;
  sel_t            fw_a_sel_q, fw_a_sel_d, fw_b_sel_q, fw_b_sel_d;

  match_t m_a, m_b;
  logic   fwd_a, fwd_b, haz_a, haz_b, hazard, stall_fe;
  cnt_t   w_a, w_b, w;

  // Scanning oldest to youngest lets the youngest (lowest index) match win.
  function automatic match_t youngest(input logic [RW-1:0]      rs,
                                      input logic               rs_use,
                                      input logic [NSTG*RW-1:0] rd,
                                      input logic [NSTG-1:0]    wr,
                                      input logic [NSTG-1:0]    bub);
    match_t m;
    m = '0;
    for (int i = NSTG - 1; i >= 0; i--) begin
      if (rs_use && rs != '0 && wr[i] && !bub[i] && rd[i*RW +: RW] == rs) begin
        m.hit = 1'b1;
        m.idx = sel_t'(i);
      end
    end
    return m;
  endfunction

  always_comb begin
    m_a = youngest(haz.id_rs1, haz.id_rs1_use, haz.st_rd, haz.st_wr, bubble_q);
    m_b = youngest(haz.id_rs2, haz.id_rs2_use, haz.st_rd, haz.st_wr, bubble_q);
`ifdef HAZ_FWD_EN
    fwd_a = m_a.hit && haz.st_rdy[m_a.idx] && !haz.id_no_fw;
    fwd_b = m_b.hit && haz.st_rdy[m_b.idx] && !haz.id_no_fw;
    // A pending load only needs one cycle before it is re-checked.
    w_a = (!haz.st_rdy[m_a.idx] && !haz.id_no_fw) ? cnt_t'(1) : cnt_t'(NSTG) - cnt_t'(m_a.idx);
    w_b = (!haz.st_rdy[m_b.idx] && !haz.id_no_fw) ? cnt_t'(1) : cnt_t'(NSTG) - cnt_t'(m_b.idx);
`else
    fwd_a = 1'b0;
    fwd_b = 1'b0;
    w_a   = cnt_t'(NSTG) - cnt_t'(m_a.idx);
    w_b   = cnt_t'(NSTG) - cnt_t'(m_b.idx);
`endif
    haz_a    = m_a.hit && !fwd_a;
    haz_b    = m_b.hit && !fwd_b;
    hazard   = (stall_cnt_q == '0) && !haz.bus_stall && (haz_a || haz_b);
    w        = (haz_a && (!haz_b || w_a >= w_b)) ? w_a : w_b;
    stall_fe = haz.bus_stall || (stall_cnt_q != '0) || hazard;
  end

`ifndef HAZ_FWD_EN
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = haz.id_no_fw ^ (^haz.st_rdy);
`endif

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    stall_cnt_d = stall_cnt_q;
    bubble_d    = bubble_q;
    fw_a_en_d   = fw_a_en_q;
    fw_a_sel_d  = fw_a_sel_q;
    fw_b_en_d   = fw_b_en_q;
    fw_b_sel_d  = fw_b_sel_q;
    if (!haz.bus_stall) begin
      bubble_d = {bubble_q[NSTG-2:0], stall_fe};
      if (hazard)                  stall_cnt_d = w - cnt_t'(1);
      else if (stall_cnt_q != '0)  stall_cnt_d = stall_cnt_q - cnt_t'(1);
      if (!stall_fe) begin
        fw_a_en_d  = fwd_a;
        fw_a_sel_d = fwd_a ? m_a.idx : '0;
        fw_b_en_d  = fwd_b;
        fw_b_sel_d = fwd_b ? m_b.idx : '0;
      end else begin
        fw_a_en_d = 1'b0;
        fw_b_en_d = 1'b0;
      end
    end
  end

  // NOTE: non-blocking assignments so every register samples the same pre-edge state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      bubble_q    <= '1;
      fw_a_en_q   <= 1'b0;
      fw_a_sel_q  <= '0;
      fw_b_en_q   <= 1'b0;
      fw_b_sel_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      bubble_q    <= bubble_d;
      fw_a_en_q   <= fw_a_en_d;
      fw_a_sel_q  <= fw_a_sel_d;
      fw_b_en_q   <= fw_b_en_d;
      fw_b_sel_q  <= fw_b_sel_d;
    end
  end

  assign haz.stall_fe  = stall_fe;
  assign haz.be_bubble = bubble_q;
  assign haz.fw_a_en   = fw_a_en_q;
  assign haz.fw_a_sel  = fw_a_sel_q;
  assign haz.fw_b_en   = fw_b_en_q;
  assign haz.fw_b_sel  = fw_b_sel_q;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit (NSTG=3, NREG=32); forwarding cases follow HAZ_FWD_EN.
module tb_hazard_unit;
  localparam int NSTG = 3;
  localparam int NREG = 32;
  localparam int RW   = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_unit_if #(.NSTG(NSTG), .NREG(NREG)) hif ();
  hazard_unit #(.NSTG(NSTG), .NREG(NREG)) dut (.clk(clk), .rst(rst), .haz(hif.slave));

  typedef struct {
    string      tag;
    logic [2:0] bub;
    logic       a_en;
    logic [1:0] a_sel;
    logic       b_en;
    logic [1:0] b_sel;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   stall_cycles = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic [4:0] rs1, input bit u1, input logic [4:0] rs2,
                        input bit u2, input bit nofw);
    hif.id_rs1 = rs1; hif.id_rs1_use = u1;
    hif.id_rs2 = rs2; hif.id_rs2_use = u2;
    hif.id_no_fw = nofw;
  endtask

  task automatic set_st(input int i, input logic [4:0] rd, input bit wr, input bit rdy);
    hif.st_rd[i*RW +: RW] = rd;
    hif.st_wr[i]  = wr;
    hif.st_rdy[i] = rdy;
  endtask

  task automatic clear_all();
    hif.bus_stall = 1'b0;
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    hif.st_rd = '0; hif.st_wr = '0; hif.st_rdy = '0;
  endtask

  // Called one time unit after a rising edge with inputs already applied.
  task automatic cyc(input string tag, input bit stall, input logic [2:0] bub,
                     input bit a_en, input logic [1:0] a_sel,
                     input bit b_en, input logic [1:0] b_sel);
    exp_t e;
    #1;
    check({tag, " stall_fe"}, 32'(hif.stall_fe), 32'(stall));
    if (hif.stall_fe === 1'b1) stall_cycles++;
    e.tag = tag; e.bub = bub; e.a_en = a_en; e.a_sel = a_sel; e.b_en = b_en; e.b_sel = b_sel;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, " be_bubble"}, 32'(hif.be_bubble), 32'(e.bub));
    check({e.tag, " fw_a_en"},   32'(hif.fw_a_en),   32'(e.a_en));
    check({e.tag, " fw_b_en"},   32'(hif.fw_b_en),   32'(e.b_en));
    if (e.a_en) check({e.tag, " fw_a_sel"}, 32'(hif.fw_a_sel), 32'(e.a_sel));
    if (e.b_en) check({e.tag, " fw_b_sel"}, 32'(hif.fw_b_sel), 32'(e.b_sel));
  endtask

  // Three stall-free cycles leave an empty back end with no bubbles.
  task automatic flush(input string tag);
    clear_all();
    repeat (3) @(posedge clk);
    #1;
    check({tag, " be_bubble"}, 32'(hif.be_bubble), 32'h0);
    check({tag, " stall_fe"},  32'(hif.stall_fe),  32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clear_all();
    repeat (2) @(posedge clk);
    #1;
    check("reset be_bubble", 32'(hif.be_bubble), 32'h7);
    check("reset fw_a_en",   32'(hif.fw_a_en),   32'h0);
    check("reset fw_b_en",   32'(hif.fw_b_en),   32'h0);
    check("reset fw_a_sel",  32'(hif.fw_a_sel),  32'h0);
    check("reset fw_b_sel",  32'(hif.fw_b_sel),  32'h0);
    check("reset stall_fe",  32'(hif.stall_fe),  32'h0);
    rst = 1'b0;

    // No stage writes x5: ID advances, bubbles drain out.
    set_id(5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    cyc("t1_c0", 1'b0, 3'b110, 1'b0, 2'd0, 1'b0, 2'd0);
    cyc("t1_c1", 1'b0, 3'b100, 1'b0, 2'd0, 1'b0, 2'd0);
    cyc("t1_c2", 1'b0, 3'b000, 1'b0, 2'd0, 1'b0, 2'd0);

`ifdef HAZ_FWD_EN
    set_st(0, 5'd5, 1'b1, 1'b1);
    set_st(2, 5'd7, 1'b1, 1'b1);
    set_id(5'd5, 1'b1, 5'd7, 1'b1, 1'b0);
    cyc("t2_fwd", 1'b0, 3'b000, 1'b1, 2'd0, 1'b1, 2'd2);
    hif.bus_stall = 1'b1;
    cyc("t2_hold", 1'b1, 3'b000, 1'b1, 2'd0, 1'b1, 2'd2);
    clear_all();
    cyc("t2_idle", 1'b0, 3'b000, 1'b0, 2'd0, 1'b0, 2'd0);

    set_st(0, 5'd5, 1'b1, 1'b0);
    set_id(5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    cyc("t3_load", 1'b1, 3'b001, 1'b0, 2'd0, 1'b0, 2'd0);
    set_st(0, 5'd0, 1'b0, 1'b0);
    set_st(1, 5'd5, 1'b1, 1'b1);
    cyc("t3_fwd", 1'b0, 3'b010, 1'b1, 2'd1, 1'b0, 2'd0);
    flush("t3_flush");
`else
    // Without forwarding: W = max(3-0, 3-2) = 3 regardless of st_rdy.
    set_st(0, 5'd5, 1'b1, 1'b1);
    set_st(2, 5'd7, 1'b1, 1'b1);
    set_id(5'd5, 1'b1, 5'd7, 1'b1, 1'b0);
    cyc("t2nf_c0", 1'b1, 3'b001, 1'b0, 2'd0, 1'b0, 2'd0);
    cyc("t2nf_c1", 1'b1, 3'b011, 1'b0, 2'd0, 1'b0, 2'd0);
    cyc("t2nf_c2", 1'b1, 3'b111, 1'b0, 2'd0, 1'b0, 2'd0);
    cyc("t2nf_c3", 1'b0, 3'b110, 1'b0, 2'd0, 1'b0, 2'd0);
    flush("t2nf_flush");

    set_st(0, 5'd5, 1'b1, 1'b0);
    set_id(5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    cyc("ldnf_c0", 1'b1, 3'b001, 1'b0, 2'd0, 1'b0, 2'd0);
    cyc("ldnf_c1", 1'b1, 3'b011, 1'b0, 2'd0, 1'b0, 2'd0);
    cyc("ldnf_c2", 1'b1, 3'b111, 1'b0, 2'd0, 1'b0, 2'd0);
    cyc("ldnf_c3", 1'b0, 3'b110, 1'b0, 2'd0, 1'b0, 2'd0);
    flush("ldnf_flush");

    set_st(1, 5'd5, 1'b1, 1'b1);
    set_id(5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    cyc("t6_c0", 1'b1, 3'b001, 1'b0, 2'd0, 1'b0, 2'd0);
    cyc("t6_c1", 1'b1, 3'b011, 1'b0, 2'd0, 1'b0, 2'd0);
    cyc("t6_c2", 1'b0, 3'b110, 1'b0, 2'd0, 1'b0, 2'd0);
    flush("t6_flush");
`endif

    // Branch on x5 produced in EX: drain through writeback, then advance.
    set_st(0, 5'd5, 1'b1, 1'b1);
    set_id(5'd5, 1'b1, 5'd0, 1'b0, 1'b1);
    cyc("t4_c0", 1'b1, 3'b001, 1'b0, 2'd0, 1'b0, 2'd0);
    cyc("t4_c1", 1'b1, 3'b011, 1'b0, 2'd0, 1'b0, 2'd0);
    cyc("t4_c2", 1'b1, 3'b111, 1'b0, 2'd0, 1'b0, 2'd0);
    cyc("t4_c3", 1'b0, 3'b110, 1'b0, 2'd0, 1'b0, 2'd0);
    flush("t4_flush");

    // Same W=3 hazard with a 4-cycle bus freeze after the first stall cycle.
    stall_cycles = 0;
    set_st(0, 5'd5, 1'b1, 1'b1);
    set_id(5'd5, 1'b1, 5'd0, 1'b0, 1'b1);
    cyc("t5_c0", 1'b1, 3'b001, 1'b0, 2'd0, 1'b0, 2'd0);
    hif.bus_stall = 1'b1;
    repeat (4) cyc("t5_frz", 1'b1, 3'b001, 1'b0, 2'd0, 1'b0, 2'd0);
    hif.bus_stall = 1'b0;
    cyc("t5_c1", 1'b1, 3'b011, 1'b0, 2'd0, 1'b0, 2'd0);
    cyc("t5_c2", 1'b1, 3'b111, 1'b0, 2'd0, 1'b0, 2'd0);
    cyc("t5_c3", 1'b0, 3'b110, 1'b0, 2'd0, 1'b0, 2'd0);
    check("t5 stall count", 32'(stall_cycles), 32'd7);
    flush("t5_flush");

    // x0 is never a dependency.
    set_st(0, 5'd0, 1'b1, 1'b1);
    set_id(5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
    cyc("x0", 1'b0, 3'b000, 1'b0, 2'd0, 1'b0, 2'd0);

    // Reset in the middle of a stall clears everything at once.
    set_st(0, 5'd5, 1'b1, 1'b1);
    set_id(5'd5, 1'b1, 5'd0, 1'b0, 1'b1);
    cyc("rst_c0", 1'b1, 3'b001, 1'b0, 2'd0, 1'b0, 2'd0);
    rst = 1'b1;
    #1;
    check("rst_mid be_bubble", 32'(hif.be_bubble), 32'h7);
    check("rst_mid stall_fe",  32'(hif.stall_fe),  32'h0);
    rst = 1'b0;
    clear_all();
    cyc("rst_after", 1'b0, 3'b110, 1'b0, 2'd0, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
